chunk_elem_streamer: RTL and testbench

//  Consumes one NUM_BITS chunk from the local BRAM's chunk output and streams it as ELEM_W-bit

---
 rtl/chunk_elem_streamer_pkg.sv | 20 ++
 rtl/chunk_elem_mux.sv | 32 +++
 rtl/chunk_elem_streamer.sv | 137 +++++++++++++
 tb/tb_chunk_elem_streamer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chunk_elem_streamer_pkg.sv
// Shared defaults for the chunk-to-element streaming path: element width, matrix
// shape and chunk size, plus the streamer FSM state encoding.
package chunk_elem_streamer_pkg;

    localparam int DEF_ELEM_W     = 8;
    localparam int DEF_ROWS       = 8;
    localparam int DEF_COLS       = 8;
    localparam int DEF_CHUNK_BITS = DEF_ROWS * DEF_COLS * DEF_ELEM_W;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    // Counter/index width that never collapses to zero bits for a dimension of 1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_elem_mux.sv
// Combinational element select: returns element (row*COLS + col) of the shadow chunk,
// element k occupying bits [ELEM_W*k +: ELEM_W].
module chunk_elem_mux
    import chunk_elem_streamer_pkg::*;
#(
    parameter int NUM_BITS = DEF_CHUNK_BITS,
    parameter int ELEM_W   = DEF_ELEM_W,
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    localparam int RW      = idx_w(ROWS),
    localparam int CW      = idx_w(COLS),
    localparam int N       = ROWS * COLS,
    localparam int IW      = idx_w(N)
) (
    input  logic [NUM_BITS-1:0] shadow_i,
    input  logic [RW-1:0]       row_i,
    input  logic [CW-1:0]       col_i,
    output logic [ELEM_W-1:0]   elem_o
);

    logic [ELEM_W-1:0] elems [N];
    logic [IW-1:0]     idx;

    for (genvar k = 0; k < N; k++) begin : g_split
        assign elems[k] = shadow_i[ELEM_W*k +: ELEM_W];
    end

    // Multiply by a constant column count; synthesis folds this into shifts/adds.
    assign idx    = IW'(row_i) * IW'(COLS) + IW'(col_i);
    assign elem_o = elems[idx];

endmodule

// File: rtl/chunk_elem_streamer.sv
// Captures one chunk from the BRAM and streams it out element by element, row-major
// or column-major, tagging each element with its source row/col.
module chunk_elem_streamer
    import chunk_elem_streamer_pkg::*;
#(
    parameter int NUM_BITS = DEF_CHUNK_BITS,
    parameter int ELEM_W   = DEF_ELEM_W,
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    localparam int RW      = idx_w(ROWS),
    localparam int CW      = idx_w(COLS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] chunk_in,
    input  logic                chunk_valid,
    output logic                chunk_ready,
    input  logic                transpose,
    input  logic                flush,
    output logic [ELEM_W-1:0]   elem_data,
    output logic [RW-1:0]       elem_row,
    output logic [CW-1:0]       elem_col,
    output logic                elem_valid,
    input  logic                elem_ready,
    output logic                elem_last,
    output logic                busy,
    output state_e              dbg_state
);

    localparam logic [RW-1:0] R_END = RW'(ROWS - 1);
    localparam logic [CW-1:0] C_END = CW'(COLS - 1);

    state_e              state_q, state_d;
    logic [NUM_BITS-1:0] shadow_q, shadow_d;
    logic [RW-1:0]       r_q, r_d;
    logic [CW-1:0]       c_q, c_d;
    logic                tmode_q, tmode_d;
    logic                r_at_end, c_at_end, at_last;
    logic [ELEM_W-1:0]   sel_elem;

    assign r_at_end = (r_q == R_END);
    assign c_at_end = (c_q == C_END);
    assign at_last  = r_at_end && c_at_end;

    // Both ports are valid/ready: a transfer happens on a rising edge where valid and
    // ready are both high; a producer holding valid keeps its payload stable until then.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        tmode_d  = tmode_q;
        r_d      = r_q;
        c_d      = c_q;
        if (flush) begin
            state_d = ST_IDLE;
            r_d     = '0;
            c_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (chunk_valid) begin
                        shadow_d = chunk_in;
                        tmode_d  = transpose;
                        r_d      = '0;
                        c_d      = '0;
                        state_d  = ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (elem_ready) begin
                        if (at_last) begin
                            state_d = ST_IDLE;
                            r_d     = '0;
                            c_d     = '0;
                        end else if (!tmode_q) begin
                            if (c_at_end) begin
                                c_d = '0;
                                r_d = r_q + 1'b1;
                            end else begin
                                c_d = c_q + 1'b1;
                            end
                        end else begin
                            if (r_at_end) begin
                                r_d = '0;
                                c_d = c_q + 1'b1;
                            end else begin
                                r_d = r_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // A single-row or single-column matrix keeps that index tied to zero.
        if (ROWS == 1) r_d = '0;
        if (COLS == 1) c_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            tmode_q  <= 1'b0;
            r_q      <= '0;
            c_q      <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            tmode_q  <= tmode_d;
            r_q      <= r_d;
            c_q      <= c_d;
        end
    end

    chunk_elem_mux #(
        .NUM_BITS (NUM_BITS),
        .ELEM_W   (ELEM_W),
        .ROWS     (ROWS),
        .COLS     (COLS)
    ) u_mux (
        .shadow_i (shadow_q),
        .row_i    (r_q),
        .col_i    (c_q),
        .elem_o   (sel_elem)
    );

    // Outputs are forced low while reset is asserted, independent of the registers.
    assign chunk_ready = rst && (state_q == ST_IDLE);
    assign elem_valid  = rst && (state_q == ST_STREAM);
    assign busy        = elem_valid;
    assign elem_data   = elem_valid ? sel_elem : '0;
    assign elem_row    = elem_valid ? r_q : '0;
    assign elem_col    = elem_valid ? c_q : '0;
    assign elem_last   = elem_valid && at_last;
    assign dbg_state   = rst ? state_q : ST_IDLE;

endmodule

// File: tb/tb_chunk_elem_streamer.sv
// Directed bench for chunk_elem_streamer: reset, row-major, transposed, backpressure,
// flush and mid-stream reset, with an expected-element queue built from the chunk.
module tb_chunk_elem_streamer;
    import chunk_elem_streamer_pkg::*;

    localparam int W = 16;  // {valid, last, row[2:0], col[2:0], data[7:0]}

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] chunk_in;
    logic         chunk_valid;
    logic         chunk_ready;
    logic         transpose;
    logic         flush;
    logic [7:0]   elem_data;
    logic [2:0]   elem_row;
    logic [2:0]   elem_col;
    logic         elem_valid;
    logic         elem_ready;
    logic         elem_last;
    logic         busy;
    state_e       dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_log[$];

    chunk_elem_streamer dut (
        .clk         (clk),
        .rst         (rst),
        .chunk_in    (chunk_in),
        .chunk_valid (chunk_valid),
        .chunk_ready (chunk_ready),
        .transpose   (transpose),
        .flush       (flush),
        .elem_data   (elem_data),
        .elem_row    (elem_row),
        .elem_col    (elem_col),
        .elem_valid  (elem_valid),
        .elem_ready  (elem_ready),
        .elem_last   (elem_last),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] sample_out();
        return {elem_valid, elem_last, elem_row, elem_col, elem_data};
    endfunction

    function automatic void push_expected(input logic [511:0] d, input logic tm);
        for (int o = 0; o < 8; o++) begin
            for (int i = 0; i < 8; i++) begin
                int r;
                int c;
                logic [7:0] v;
                r = tm ? i : o;
                c = tm ? o : i;
                v = d[(r*8+c)*8 +: 8];
                exp_q.push_back({1'b1, (r == 7 && c == 7), 3'(r), 3'(c), v});
            end
        end
    endfunction

    function automatic logic [511:0] ramp_chunk();
        logic [511:0] d;
        for (int k = 0; k < 64; k++) d[k*8 +: 8] = 8'(k + 1);
        return d;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_chunk(input logic [511:0] d, input logic tm);
        int n = 0;
        @(negedge clk);
        while (!chunk_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("chunk_ready_wait", {31'd0, chunk_ready}, 32'd1);
        check("idle_no_valid", {31'd0, elem_valid}, 32'd0);
        chunk_in    = d;
        transpose   = tm;
        chunk_valid = 1'b1;
        @(posedge clk);
        #1;
        chunk_valid = 1'b0;
        transpose   = 1'b0;
    endtask

    // Consume nbeats elements; with rand_rdy the ready line toggles randomly.
    task automatic stream(input int nbeats, input bit rand_rdy);
        int beats = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [W-1:0] held = '0;
        logic [W-1:0] obs;
        logic [W-1:0] exp;
        obs_log.delete();
        while (beats < nbeats && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            obs = sample_out();
            if (cyc == 1) check("ready_low_streaming", {31'd0, chunk_ready}, 32'd0);
            if (stalled) check("stall_hold", 32'(obs), 32'(held));
            if (elem_valid && elem_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(obs), 32'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check("beat", 32'(obs), 32'(exp));
                end
                obs_log.push_back(obs);
                beats++;
                stalled = 0;
            end else begin
                stalled = elem_valid;
                held    = obs;
            end
            @(posedge clk);
            #1;
            elem_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (beats < nbeats) check("stream_timeout", 32'(beats), 32'(nbeats));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [511:0] ramp;
        logic [511:0] rnd;
        rst         = 1'b0;
        chunk_in    = '0;
        chunk_valid = 1'b0;
        transpose   = 1'b0;
        flush       = 1'b0;
        elem_ready  = 1'b1;
        ramp        = ramp_chunk();

        // Reset
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_chunk_ready", {31'd0, chunk_ready}, 32'd0);
        check("rst_elem_valid", {31'd0, elem_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_elem_data", {24'd0, elem_data}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_ready", {31'd0, chunk_ready}, 32'd1);
        check("post_rst_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});

        // Row-major
        push_expected(ramp, 1'b0);
        send_chunk(ramp, 1'b0);
        stream(64, 0);
        check("rm_first_data", {24'd0, obs_log[0][7:0]}, 32'd1);
        check("rm_beat9_rowcol", {26'd0, obs_log[8][13:8]}, {26'd0, 3'd1, 3'd0});
        check("rm_last_data", {24'd0, obs_log[63][7:0]}, 32'd64);
        @(negedge clk);
        check("rm_ready_after", {31'd0, chunk_ready}, 32'd1);
        check("rm_valid_after", {31'd0, elem_valid}, 32'd0);
        check("rm_busy_after", {31'd0, busy}, 32'd0);

        // Transposed
        push_expected(ramp, 1'b1);
        send_chunk(ramp, 1'b1);
        stream(64, 0);
        check("tp_beat2_data", {24'd0, obs_log[1][7:0]}, 32'd9);
        check("tp_beat2_rowcol", {26'd0, obs_log[1][13:8]}, {26'd0, 3'd1, 3'd0});
        check("tp_beat9_data", {24'd0, obs_log[8][7:0]}, 32'd2);
        check("tp_beat9_rowcol", {26'd0, obs_log[8][13:8]}, {26'd0, 3'd0, 3'd1});
        check("tp_beat8_last", {31'd0, obs_log[7][14]}, 32'd0);

        // Backpressure
        push_expected(ramp, 1'b0);
        send_chunk(ramp, 1'b0);
        stream(64, 1);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Flush after beat 10
        elem_ready = 1'b1;
        push_expected(ramp, 1'b0);
        send_chunk(ramp, 1'b0);
        stream(10, 0);
        elem_ready = 1'b0;
        flush      = 1'b1;
        @(negedge clk);
        check("flush_pre_valid", {31'd0, elem_valid}, 32'd1);
        check("flush_pre_data", {24'd0, elem_data}, 32'd11);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_valid", {31'd0, elem_valid}, 32'd0);
        check("flush_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        elem_ready = 1'b1;
        push_expected({64{8'hA5}}, 1'b0);
        send_chunk({64{8'hA5}}, 1'b0);
        stream(64, 0);
        check("a5_first_rowcol", {26'd0, obs_log[0][13:8]}, 32'd0);

        // Flush and capture in the same idle cycle
        @(negedge clk);
        flush       = 1'b1;
        chunk_valid = 1'b1;
        chunk_in    = ramp;
        @(posedge clk);
        #1;
        flush       = 1'b0;
        chunk_valid = 1'b0;
        @(negedge clk);
        check("flush_beats_capture", {31'd0, busy}, 32'd0);

        // Mid-stream reset at beat 30
        push_expected(ramp, 1'b1);
        send_chunk(ramp, 1'b1);
        stream(30, 0);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_valid", {31'd0, elem_valid}, 32'd0);
        check("mrst_ready", {31'd0, chunk_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mrst_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
        exp_q.delete();
        for (int k = 0; k < 16; k++) rnd[k*32 +: 32] = $urandom;
        push_expected(rnd, 1'b0);
        send_chunk(rnd, 1'b0);
        stream(64, 0);
        check("mrst_first_data", {24'd0, obs_log[0][7:0]}, {24'd0, rnd[7:0]});

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
